hash_sched: RTL
===============

HASH_SCHED -- requirements
Module: hash_sched

Interface
REQ-001 SHALL have parameter WORDS_PER_PACK, default 5, meaning 16-bit random words per fifo2 shift (5 trits per lane).
REQ-002 SHALL have parameter PACKS_PER_BLOCK, default 68, meaning fifo2 shifts per 1088-bit rate block.
REQ-003 SHALL have parameter FINAL_PACKS, default 4, meaning fifo2 shifts in the padded final block (64 remaining bits).
REQ-004 SHALL have parameter ROUNDS, default 24, meaning Keccak-f rounds per permutation.
REQ-005 SHALL use one clock, clk; reset is asynchronous and active-low, ovr_rst_n.
REQ-006 Ports SHALL be:
clk  in  1  rising-edge clock.
ovr_rst_n  in  1  async active-low reset.
start  in  1  begin a hash; sampled in IDLE only.
num_blk  in  4  full rate blocks before the final block; latched on start.
bits_valid  in  1  random word available.
bits_ready  out  1  controller accepts a word this cycle.
fifo1_en  out  1  shift trit FIFO (one-cycle pulse per accepted word).
p3_rst  out  1  clear trit-to-byte packers.
fifo2_en  out  1  shift 16 packed bits into the message register.
hash_init  out  1  clear sponge state.
hash_absorb  out  1  XOR padded block into state.
hash_round  out  1  perform one permutation round.
rc_idx  out  5  round-constant index.
hash_fin  out  1  final-block padding select.
busy  out  1  not IDLE.
done  out  1  one-cycle pulse; digest valid.

Function
REQ-007 SHALL implement states IDLE, INIT, FILL, PACK, ABSORB, PERM and DONE.
REQ-008 IDLE: bits_ready=0; start=1 -> latch num_blk, clear counters, go to INIT; set final=1 when num_blk=0.
REQ-009 INIT: hash_init=1 and p3_rst=1 for one cycle -> FILL.
REQ-010 FILL: bits_ready=1; fifo1_en=bits_valid; word_cnt increments per accepted word; at the accept that makes word_cnt=WORDS_PER_PACK -> PACK, word_cnt=0.
REQ-011 PACK: one cycle, bits_ready=0, fifo2_en=1, p3_rst=1, pack_cnt++; pack_cnt reaching target (PACKS_PER_BLOCK, or FINAL_PACKS when final=1) -> ABSORB, else FILL.
REQ-012 ABSORB: hash_absorb=1 for one cycle, pack_cnt=0 -> PERM with rc_idx=0.
REQ-013 PERM: hash_round=1 every cycle, rc_idx 0..ROUNDS-1; after round ROUNDS-1 -> DONE if final=1; else decrement blk_cnt and -> FILL, setting final=1 when blk_cnt reaches 0.
REQ-014 DONE: done=1 for one cycle -> IDLE.
REQ-015 hash_fin SHALL equal final, held from entry to the final FILL through DONE; 0 otherwise.
REQ-016 bits_valid without bits_ready SHALL have no effect; a stalled word_cnt SHALL hold its value.
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 rc_idx SHALL be 0 outside PERM.
REQ-019 Latency with bits_valid held at 1: done SHALL occur (1+(num_blk)*433+49+1) cycles after the start cycle, where 433=68*6+1+24 and 49=4*6+1+24.

Reset
REQ-020 ovr_rst_n=0 SHALL force IDLE asynchronously, even mid-operation; all counters SHALL be 0 and all outputs 0.
REQ-021 The first hash after reset release SHALL require a new start.

Configuration
REQ-022 With HASH_SCHED_ABORT_EN defined, an input port abort (1 bit) SHALL exist; abort=1 in any non-IDLE state SHALL return the block to IDLE on the next edge, pulse hash_init and p3_rst in that cycle, clear counters and assert no done.
REQ-023 Without HASH_SCHED_ABORT_EN, the port SHALL be absent and the FSM SHALL run to DONE once started.

Verification
REQ-024 Reset then start with num_blk=0 and bits_valid=1 -> hash_init at cycle 1; 20 fifo1_en, 4 fifo2_en, 1 hash_absorb, 24 hash_round (rc_idx 0..23); hash_fin=1 throughout; done at cycle 51.
REQ-025 num_blk=1 with bits_valid=1 -> 340+20 fifo1_en, 72 fifo2_en, 2 hash_absorb (hash_fin=0 on the first, 1 on the second), 48 hash_round; done at cycle 484.
REQ-026 bits_valid toggled 1/0 every cycle, num_blk=0 -> fifo1_en count still 20; word_cnt holds while stalled; done delayed by exactly the number of stalled FILL cycles.
REQ-027 start pulsed during PERM -> ignored; num_blk unchanged; single done pulse.
REQ-028 ovr_rst_n driven low during the 10th PERM cycle -> all outputs 0 immediately; busy=0; no done; a new start completes normally.
REQ-029 HASH_SCHED_ABORT_EN defined, abort during FILL (pack 30) -> IDLE next cycle with hash_init=1, p3_rst=1 and no done; a subsequent num_blk=0 run matches REQ-024.

Source files
------------

// File: rtl/hash_sched.sv
// -----------------------------------------------------------------------------
// hash_sched -- control scheduler for a trit-sampling SHA3-style sponge.
//
// Pulls 16-bit random words into the trit FIFO, packs WORDS_PER_PACK words
// into each 16-bit message shift, and absorbs the result one rate block at a
// time. After each absorb it sequences ROUNDS Keccak-f rounds. num_blk full
// blocks are followed by one short padded final block. done pulses once when
// the digest is valid.
//
// Ports:
//   clk          rising-edge clock
//   ovr_rst_n    asynchronous active-low reset
//   start        begin a hash (sampled in IDLE only)
//   num_blk[3:0] full rate blocks before the final block (latched on start)
//   abort        (HASH_SCHED_ABORT_EN only) return to IDLE from any state
//   bits_valid   random word available
//   bits_ready   controller accepts a word this cycle
//   fifo1_en     shift trit FIFO, one pulse per accepted word
//   p3_rst       clear trit-to-byte packers
//   fifo2_en     shift 16 packed bits into the message register
//   hash_init    clear sponge state
//   hash_absorb  XOR padded block into state
//   hash_round   perform one permutation round
//   rc_idx[4:0]  round-constant index (0 outside PERM)
//   hash_fin     final-block padding select
//   busy         not IDLE
//   done         one-cycle pulse, digest valid
//
// Optional feature macro: HASH_SCHED_ABORT_EN adds the abort input.
//
// Handshake: a word transfers on every cycle where bits_valid && bits_ready
// are both high; bits_ready is high only in FILL and does not depend on
// bits_valid. bits_valid while bits_ready is low is ignored.
// -----------------------------------------------------------------------------
module hash_sched #(
    parameter int WORDS_PER_PACK  = 5,
    parameter int PACKS_PER_BLOCK = 68,
    parameter int FINAL_PACKS     = 4,
    parameter int ROUNDS          = 24
) (
    input  logic       clk,
    input  logic       ovr_rst_n,
    input  logic       start,
    input  logic [3:0] num_blk,
`ifdef HASH_SCHED_ABORT_EN
    input  logic       abort,
`endif
    input  logic       bits_valid,
    output logic       bits_ready,
    output logic       fifo1_en,
    output logic       p3_rst,
    output logic       fifo2_en,
    output logic       hash_init,
    output logic       hash_absorb,
    output logic       hash_round,
    output logic [4:0] rc_idx,
    output logic       hash_fin,
    output logic       busy,
    output logic       done
);

    localparam int WC_W = $clog2(WORDS_PER_PACK + 1);
    localparam int PC_W = $clog2(PACKS_PER_BLOCK + 1);

    localparam logic [WC_W-1:0] WORD_LAST      = WC_W'(WORDS_PER_PACK - 1);
    localparam logic [PC_W-1:0] PACK_LAST_FULL = PC_W'(PACKS_PER_BLOCK - 1);
    localparam logic [PC_W-1:0] PACK_LAST_FIN  = PC_W'(FINAL_PACKS - 1);
    localparam logic [4:0]      RND_LAST       = 5'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FILL,
        S_PACK,
        S_ABSORB,
        S_PERM,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WC_W-1:0]   word_cnt;
    logic [PC_W-1:0]   pack_cnt;
    logic [3:0]        blk_cnt;
    logic [4:0]        rnd_cnt;
    logic              final_q;   // current block is the padded final block

    logic              abort_hit;
    logic              accept;
    logic              word_last;
    logic              pack_last;
    logic              rnd_last;

`ifdef HASH_SCHED_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign accept    = (state == S_FILL) && bits_valid;
    assign word_last = (word_cnt == WORD_LAST);
    assign pack_last = (pack_cnt == (final_q ? PACK_LAST_FIN : PACK_LAST_FULL));
    assign rnd_last  = (rnd_cnt == RND_LAST);

    // Next state and Moore-style strobes.
    always_comb begin
        state_nxt   = state;
        bits_ready  = 1'b0;
        fifo1_en    = 1'b0;
        p3_rst      = 1'b0;
        fifo2_en    = 1'b0;
        hash_init   = 1'b0;
        hash_absorb = 1'b0;
        hash_round  = 1'b0;
        done        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_INIT;
            end
            S_INIT: begin
                hash_init = 1'b1;
                p3_rst    = 1'b1;
                state_nxt = S_FILL;
            end
            S_FILL: begin
                bits_ready = 1'b1;
                fifo1_en   = bits_valid;
                if (bits_valid && word_last) state_nxt = S_PACK;
            end
            S_PACK: begin
                fifo2_en  = 1'b1;
                p3_rst    = 1'b1;
                state_nxt = pack_last ? S_ABSORB : S_FILL;
            end
            S_ABSORB: begin
                hash_absorb = 1'b1;
                state_nxt   = S_PERM;
            end
            S_PERM: begin
                hash_round = 1'b1;
                if (rnd_last) state_nxt = final_q ? S_DONE : S_FILL;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Abort wins over everything: wipe the sponge/packers on the way out
        // and never let a done escape.
        if (abort_hit) begin
            state_nxt   = S_IDLE;
            bits_ready  = 1'b0;
            fifo1_en    = 1'b0;
            fifo2_en    = 1'b0;
            hash_absorb = 1'b0;
            hash_round  = 1'b0;
            done        = 1'b0;
            hash_init   = 1'b1;
            p3_rst      = 1'b1;
        end
    end

    assign busy     = (state != S_IDLE);
    assign hash_fin = final_q;
    assign rc_idx   = (state == S_PERM) ? rnd_cnt : 5'd0;

    always_ff @(posedge clk or negedge ovr_rst_n) begin
        if (!ovr_rst_n) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            pack_cnt <= '0;
            blk_cnt  <= '0;
            rnd_cnt  <= '0;
            final_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (abort_hit) begin
                word_cnt <= '0;
                pack_cnt <= '0;
                blk_cnt  <= '0;
                rnd_cnt  <= '0;
                final_q  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            blk_cnt  <= num_blk;
                            final_q  <= (num_blk == 4'd0);
                            word_cnt <= '0;
                            pack_cnt <= '0;
                            rnd_cnt  <= '0;
                        end
                    end
                    S_FILL: begin
                        // Stalled cycles leave word_cnt untouched.
                        if (accept) word_cnt <= word_last ? '0 : word_cnt + 1'b1;
                    end
                    S_PACK: begin
                        pack_cnt <= pack_last ? '0 : pack_cnt + 1'b1;
                    end
                    S_ABSORB: begin
                        pack_cnt <= '0;
                        rnd_cnt  <= '0;
                    end
                    S_PERM: begin
                        if (rnd_last) begin
                            rnd_cnt <= '0;
                            if (!final_q) begin
                                blk_cnt <= blk_cnt - 1'b1;
                                // Last full block just finished: next fill is the padded one.
                                final_q <= (blk_cnt == 4'd1);
                            end
                        end else begin
                            rnd_cnt <= rnd_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        final_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
